alu_exec_unit: RTL



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_seq_shifter.sv | 46 ++++
 rtl/alu_exec_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control code table and execute-unit FSM encoding.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;
  localparam logic [3:0] ALU_BEQ = 4'b1010;
  localparam logic [3:0] ALU_BLT = 4'b1011;
  localparam logic [3:0] ALU_BGE = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1101;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic logic is_shift(input logic [3:0] c);
    return c == ALU_SLL || c == ALU_SRL || c == ALU_SRA;
  endfunction
endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: 1 bit/cycle shifter with start/busy/done; ALU_BARREL_SHIFT_EN swaps in a combinational barrel shifter.
import alu_pkg::*;
module alu_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);
`ifdef ALU_BARREL_SHIFT_EN
  logic signed [WIDTH-1:0] sra_v;
  assign sra_v = $signed(din) >>> shamt;
  assign busy = 1'b0;
  assign done = start;
  assign dout = op == ALU_SLL ? din << shamt : op == ALU_SRA ? sra_v : din >> shamt;
`else
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op_q;
  // dout is the value after this cycle's step, so it is final while done is high
  assign busy = cnt != '0;
  assign done = cnt == SHAMT_W'(1);
  assign dout = op_q == ALU_SLL ? {sreg[WIDTH-2:0], 1'b0}
                                : {op_q == ALU_SRA && sreg[WIDTH-1], sreg[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      op_q <= ALU_AND;
    end else if (start) begin
      sreg <= din;
      cnt  <= shamt;
      op_q <= op;
    end else if (busy) begin
      sreg <= dout;
      cnt  <= cnt - 1'b1;
    end
`endif
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute unit with valid/ready handshake; ALU_BARREL_SHIFT_EN makes shifts single-cycle.
import alu_pkg::*;
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal
);
  state_t state, state_n;
  logic               accept, start, load, sh_busy, sh_done, lt, alu_br, alu_il;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   diff, alu_r, sh_dout, nres;
  assign shamt     = op_b[SHAMT_W-1:0];
  assign in_ready  = state == IDLE && !sh_busy;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_shift(alu_ctrl) && shamt != '0;
  assign diff      = op_a - op_b;
  assign lt        = $signed(op_a) < $signed(op_b);
  // zero-amount shifts fall through alu_r as op_a and never start the shifter
  always_comb begin
    alu_r  = '0;
    alu_br = 1'b0;
    alu_il = 1'b0;
    case (alu_ctrl)
      ALU_AND: alu_r = op_a & op_b;
      ALU_OR:  alu_r = op_a | op_b;
      ALU_ADD: alu_r = op_a + op_b;
      ALU_XOR: alu_r = op_a ^ op_b;
      ALU_SUB: alu_r = diff;
      ALU_SLT: alu_r = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_r = op_a;
      ALU_BNE: begin alu_r = diff; alu_br = diff != '0; end
      ALU_BEQ: begin alu_r = diff; alu_br = diff == '0; end
      ALU_BLT: begin alu_r = diff; alu_br = lt; end
      ALU_BGE: begin alu_r = diff; alu_br = !lt; end
      ALU_LUI: alu_r = op_b;
      default: alu_il = 1'b1;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = start && !sh_done ? SHIFT : DONE;
      SHIFT:   if (sh_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign load = (accept && (!start || sh_done)) || (state == SHIFT && sh_done);
  assign nres = (start || state == SHIFT) ? sh_dout : alu_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      if (accept) begin
        branch_taken <= alu_br;
        illegal      <= alu_il;
      end
      if (load) begin
        result <= nres;
        zero   <= nres == '0;
      end
    end
  alu_seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (alu_ctrl),
    .din  (op_a),
    .shamt(shamt),
    .busy (sh_busy),
    .done (sh_done),
    .dout (sh_dout)
  );
endmodule
